// File: rtl/syscall_console_pkg.sv
// Shared definitions for the syscall console unit: syscall codes, FSM states
// and the byte-lane select used when streaming a string word.
package syscall_console_pkg;

    localparam logic [31:0] SYS_PRINT_STR  = 32'd4;
    localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;
    localparam logic [31:0] SYS_EXIT       = 32'd10;
    localparam logic [7:0]  ASCII_NL       = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EMIT  = 3'd2,
        ST_CHAR  = 3'd3,
        ST_NL    = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Little-endian lane select: lane 0 is the first character in memory.
    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
        case (idx)
            2'd0:    return word[7:0];
            2'd1:    return word[15:8];
            2'd2:    return word[23:16];
            default: return word[31:24];
        endcase
    endfunction

endpackage

// File: rtl/syscall_console.sv
// Syscall service stage behind data memory: stalls the pipeline while it
// streams print_string / print_char bytes to a valid/ready console, and handles exit.
module syscall_console
    import syscall_console_pkg::*;
#(
    parameter int MAX_WORDS = 256,
    parameter bit APPEND_NL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sys,
    input  logic [31:0] regv,
    input  logic [31:0] rega,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic [7:0]  char_data,
    output logic        char_valid,
    input  logic        char_ready,
    output logic        stall,
    output logic        done,
    output logic        halt,
    output logic        overflow
);

    localparam int WCNT_W = $clog2(MAX_WORDS + 1);

    state_t              state;
    logic                sys_q;
    logic [31:0]         ptr;
    logic [31:0]         word_q;
    logic [1:0]          byte_idx;
    logic [WCNT_W-1:0]   wcnt;
    logic                stall_reg;

    logic                start;
    logic                known_code;
    logic                accept;
    logic                last_word;
    logic                string_end;
    logic [7:0]          emit_byte;
    logic [7:0]          next_byte;

    // Gated by rst_n so a held sys cannot raise stall while reset is asserted.
    assign start      = rst_n && (state == ST_IDLE) && sys && !sys_q;
    assign known_code = (regv == SYS_PRINT_STR) || (regv == SYS_PRINT_CHAR) || (regv == SYS_EXIT);
    assign stall      = stall_reg | (start & known_code);

    assign accept     = char_valid && char_ready;
    assign emit_byte  = byte_sel(word_q, byte_idx);
    assign next_byte  = byte_sel(word_q, byte_idx + 2'd1);
    assign last_word  = (wcnt == WCNT_W'(MAX_WORDS));
    assign string_end = (state == ST_EMIT) &&
                        ((emit_byte == 8'd0) || (accept && (byte_idx == 2'd3) && last_word));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            sys_q      <= 1'b0;
            ptr        <= 32'd0;
            word_q     <= 32'd0;
            byte_idx   <= 2'd0;
            wcnt       <= '0;
            stall_reg  <= 1'b0;
            mem_rd     <= 1'b0;
            mem_addr   <= 32'd0;
            char_data  <= 8'd0;
            char_valid <= 1'b0;
            done       <= 1'b0;
            halt       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            sys_q <= sys;
            case (state)
                ST_IDLE: begin
                    if (start && (regv == SYS_PRINT_STR)) begin
                        state     <= ST_FETCH;
                        ptr       <= rega;
                        wcnt      <= '0;
                        mem_rd    <= 1'b1;
                        mem_addr  <= rega;
                        stall_reg <= 1'b1;
                    end else if (start && (regv == SYS_PRINT_CHAR)) begin
                        state      <= ST_CHAR;
                        char_valid <= 1'b1;
                        char_data  <= rega[7:0];
                        stall_reg  <= 1'b1;
                    end else if (start && (regv == SYS_EXIT)) begin
                        state <= ST_DONE;
                        halt  <= 1'b1;
                        done  <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    state      <= ST_EMIT;
                    word_q     <= mem_rdata;
                    byte_idx   <= 2'd0;
                    wcnt       <= wcnt + WCNT_W'(1);
                    mem_rd     <= 1'b0;
                    char_valid <= (mem_rdata[7:0] != 8'd0);
                    char_data  <= mem_rdata[7:0];
                end
                ST_EMIT: begin
                    if (accept) begin
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3)
                            ptr <= ptr + 32'd1;
                    end
                    if (string_end) begin
                        // A non-NUL byte here means the word budget ran out.
                        if (emit_byte != 8'd0)
                            overflow <= 1'b1;
                        if (APPEND_NL) begin
                            state      <= ST_NL;
                            char_valid <= 1'b1;
                            char_data  <= ASCII_NL;
                        end else begin
                            state      <= ST_DONE;
                            char_valid <= 1'b0;
                            done       <= 1'b1;
                            stall_reg  <= 1'b0;
                        end
                    end else if (accept && (byte_idx == 2'd3)) begin
                        state      <= ST_FETCH;
                        char_valid <= 1'b0;
                        mem_rd     <= 1'b1;
                        mem_addr   <= ptr + 32'd1;
                    end else if (accept) begin
                        char_valid <= (next_byte != 8'd0);
                        char_data  <= next_byte;
                    end
                end
                ST_CHAR, ST_NL: begin
                    if (accept) begin
                        state      <= ST_DONE;
                        char_valid <= 1'b0;
                        done       <= 1'b1;
                        stall_reg  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state      <= ST_IDLE;
                    char_valid <= 1'b0;
                    mem_rd     <= 1'b0;
                    stall_reg  <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_syscall_console.sv
// Directed bench for syscall_console: string, char, exit, ignored code,
// word-budget overflow (second instance with MAX_WORDS=2) and mid-string reset.
module tb_syscall_console;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sys = 1'b0;
    logic        sys2 = 1'b0;
    logic        char_ready = 1'b0;
    logic [31:0] regv = 32'd0;
    logic [31:0] rega = 32'd0;

    logic        mem_rd_a, mem_rd_b;
    logic [31:0] mem_addr_a, mem_addr_b, mem_rdata_a, mem_rdata_b;
    logic [7:0]  char_data_a, char_data_b;
    logic        char_valid_a, char_valid_b;
    logic        stall_a, stall_b, done_a, done_b, halt_a, halt_b, overflow_a, overflow_b;

    logic [31:0] mem [0:15];

    always #5 clk = ~clk;

    assign mem_rdata_a = (mem_addr_a[31:4] == 28'h0040000) ? mem[mem_addr_a[3:0]] : 32'd0;
    assign mem_rdata_b = (mem_addr_b[31:4] == 28'h0040000) ? mem[mem_addr_b[3:0]] : 32'd0;

    syscall_console dut (
        .clk(clk), .rst_n(rst_n), .sys(sys), .regv(regv), .rega(rega),
        .mem_rd(mem_rd_a), .mem_addr(mem_addr_a), .mem_rdata(mem_rdata_a),
        .char_data(char_data_a), .char_valid(char_valid_a), .char_ready(char_ready),
        .stall(stall_a), .done(done_a), .halt(halt_a), .overflow(overflow_a)
    );

    syscall_console #(.MAX_WORDS(2), .APPEND_NL(1'b1)) dut_ovf (
        .clk(clk), .rst_n(rst_n), .sys(sys2), .regv(regv), .rega(rega),
        .mem_rd(mem_rd_b), .mem_addr(mem_addr_b), .mem_rdata(mem_rdata_b),
        .char_data(char_data_b), .char_valid(char_valid_b), .char_ready(char_ready),
        .stall(stall_b), .done(done_b), .halt(halt_b), .overflow(overflow_b)
    );

    // Selected view: 0 = default instance, 1 = MAX_WORDS=2 instance.
    logic        sel = 1'b0;
    logic        v_mem_rd, v_valid, v_stall, v_done;
    logic [31:0] v_mem_addr;
    logic [7:0]  v_data;
    assign v_mem_rd   = sel ? mem_rd_b     : mem_rd_a;
    assign v_mem_addr = sel ? mem_addr_b   : mem_addr_a;
    assign v_valid    = sel ? char_valid_b : char_valid_a;
    assign v_data     = sel ? char_data_b  : char_data_a;
    assign v_stall    = sel ? stall_b      : stall_a;
    assign v_done     = sel ? done_b       : done_a;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  got_q[$];
    logic [31:0] fetch_q[$];
    int          stall_cnt;
    bit          got_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sample every cycle from the start cycle up to and including the done pulse.
    task automatic run_op(input string name, input int budget);
        got_q.delete();
        fetch_q.delete();
        stall_cnt = 0;
        got_done  = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (v_mem_rd) fetch_q.push_back(v_mem_addr);
            if (v_valid && char_ready) got_q.push_back(v_data);
            if (v_stall) stall_cnt++;
            if (v_done) begin
                got_done = 1'b1;
                break;
            end
            step();
        end
        $display("op %s: chars=%0d fetches=%0d stall_cycles=%0d done=%0d",
                 name, got_q.size(), fetch_q.size(), stall_cnt, got_done);
        check({name, "_done_seen"}, 32'(got_done), 32'd1);
    endtask

    initial begin
        int idle_stall;
        int idle_done;
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;

        // Reset state
        step();
        step();
        check("rst_stall", 32'(stall_a), 32'd0);
        check("rst_valid", 32'(char_valid_a), 32'd0);
        check("rst_mem_rd", 32'(mem_rd_a), 32'd0);
        check("rst_halt_ovf", {30'd0, halt_a, overflow_a}, 32'd0);
        check("rst_addr_data", mem_addr_a | 32'(char_data_a), 32'd0);
        rst_n = 1'b1;
        step();

        // 1: "Hi" then newline
        mem[0] = 32'h0000_6948;
        regv = 32'd4; rega = 32'h0040_0000; char_ready = 1'b1; sys = 1'b1;
        #1;
        check("t1_start_stall", 32'(stall_a), 32'd1);
        run_op("t1", 40);
        check("t1_len", 32'(got_q.size()), 32'd3);
        check("t1_c0", 32'(got_q[0]), 32'h48);
        check("t1_c1", 32'(got_q[1]), 32'h69);
        check("t1_c2", 32'(got_q[2]), 32'h0A);
        check("t1_stall_cycles", 32'(stall_cnt), 32'd6);
        check("t1_stall_in_done", 32'(stall_a), 32'd0);
        step();
        check("t1_done_one_cycle", 32'(done_a), 32'd0);
        sys = 1'b0;
        step();

        // 2: "abcd" spans a full word, NUL found in the next fetch
        mem[0] = 32'h6463_6261;
        mem[1] = 32'h0000_0000;
        sys = 1'b1;
        #1;
        run_op("t2", 40);
        check("t2_len", 32'(got_q.size()), 32'd5);
        check("t2_c0", 32'(got_q[0]), 32'h61);
        check("t2_c3", 32'(got_q[3]), 32'h64);
        check("t2_c4", 32'(got_q[4]), 32'h0A);
        check("t2_nfetch", 32'(fetch_q.size()), 32'd2);
        check("t2_fetch0", fetch_q[0], 32'h0040_0000);
        check("t2_fetch1", fetch_q[1], 32'h0040_0001);
        check("t2_stall_cycles", 32'(stall_cnt), 32'd9);
        sys = 1'b0;
        step();
        step();

        // Unknown code: no stall, no done
        regv = 32'd5; sys = 1'b1;
        #1;
        idle_stall = 0;
        idle_done = 0;
        for (int c = 0; c < 6; c++) begin
            if (stall_a) idle_stall++;
            if (done_a) idle_done++;
            step();
        end
        check("unk_stall", 32'(idle_stall), 32'd0);
        check("unk_done", 32'(idle_done), 32'd0);
        sys = 1'b0;
        step();

        // 3: print_char with console back-pressure
        regv = 32'd11; rega = 32'h0000_0041; char_ready = 1'b0; sys = 1'b1;
        #1;
        check("t3_start_stall", 32'(stall_a), 32'd1);
        step();
        for (int c = 0; c < 5; c++) begin
            check("t3_hold_valid", 32'(char_valid_a), 32'd1);
            check("t3_hold_data", 32'(char_data_a), 32'h41);
            check("t3_hold_stall", 32'(stall_a), 32'd1);
            step();
        end
        char_ready = 1'b1;
        #1;
        check("t3_valid_at_accept", 32'(char_valid_a), 32'd1);
        step();
        check("t3_done", 32'(done_a), 32'd1);
        check("t3_valid_after", 32'(char_valid_a), 32'd0);
        check("t3_stall_after", 32'(stall_a), 32'd0);
        step();
        check("t3_done_one_cycle", 32'(done_a), 32'd0);
        sys = 1'b0;
        step();

        // 4: exit
        regv = 32'd10; sys = 1'b1;
        #1;
        check("t4_start_stall", 32'(stall_a), 32'd1);
        check("t4_halt_before", 32'(halt_a), 32'd0);
        step();
        check("t4_halt", 32'(halt_a), 32'd1);
        check("t4_done", 32'(done_a), 32'd1);
        check("t4_stall_released", 32'(stall_a), 32'd0);
        step();
        check("t4_done_one_cycle", 32'(done_a), 32'd0);
        sys = 1'b0;
        step();
        step();

        // 5: two words with no NUL on the MAX_WORDS=2 instance
        mem[4] = 32'h4443_4241;
        mem[5] = 32'h4847_4645;
        sel = 1'b1;
        regv = 32'd4; rega = 32'h0040_0004; char_ready = 1'b1; sys2 = 1'b1;
        #1;
        run_op("t5", 60);
        check("t5_len", 32'(got_q.size()), 32'd9);
        check("t5_c0", 32'(got_q[0]), 32'h41);
        check("t5_c7", 32'(got_q[7]), 32'h48);
        check("t5_c8", 32'(got_q[8]), 32'h0A);
        check("t5_nfetch", 32'(fetch_q.size()), 32'd2);
        check("t5_overflow", 32'(overflow_b), 32'd1);
        check("t5_other_no_ovf", 32'(overflow_a), 32'd0);
        idle_stall = 0;
        idle_done = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (stall_b) idle_stall++;
            if (done_b) idle_done++;
        end
        check("t5_no_restart_stall", 32'(idle_stall), 32'd0);
        check("t5_no_restart_done", 32'(idle_done), 32'd0);
        sys2 = 1'b0;
        sel = 1'b0;
        check("t4_halt_sticky", 32'(halt_a), 32'd1);
        step();

        // 6: reset during the second EMIT of "Hi"
        mem[0] = 32'h0000_6948;
        regv = 32'd4; rega = 32'h0040_0000; sys = 1'b1;
        step();
        step();
        step();
        check("t6_pre_valid", 32'(char_valid_a), 32'd1);
        check("t6_pre_data", 32'(char_data_a), 32'h69);
        rst_n = 1'b0;
        sys = 1'b0;
        #1;
        check("t6_rst_valid", 32'(char_valid_a), 32'd0);
        check("t6_rst_stall", 32'(stall_a), 32'd0);
        check("t6_rst_done", 32'(done_a), 32'd0);
        check("t6_rst_halt", 32'(halt_a), 32'd0);
        check("t6_rst_data", 32'(char_data_a), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        sys = 1'b1;
        #1;
        run_op("t6_restart", 40);
        check("t6_len", 32'(got_q.size()), 32'd3);
        check("t6_c0", 32'(got_q[0]), 32'h48);
        check("t6_c2", 32'(got_q[2]), 32'h0A);
        check("t6_stall_cycles", 32'(stall_cnt), 32'd6);
        sys = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
